posit_result_buffer: RTL

- Output stage directly downstream of the posit packing/rounding stage of the multi-precision posit FMA unit.
- Captures the packed 32-bit result word and applies per-lane zero/NaR overrides flagged by the upstream special-case path.
- Buffers results in a small FIFO with valid/ready handshakes on both sides.
- Keeps a saturating count of NaR lanes emitted.

---
 rtl/posit_pkg.sv | 31 +++
 rtl/posit_special_override.sv | 46 ++++
 rtl/posit_result_buffer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/posit_pkg.sv
// Shared posit output-path definitions: precision modes, lane activity masks,
// NaR encodings and the buffered result payload.
package posit_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = 4;

  localparam logic [1:0] PRE_P8  = 2'b00;
  localparam logic [1:0] PRE_P16 = 2'b01;
  localparam logic [1:0] PRE_P32 = 2'b10;

  localparam logic [7:0]  NAR8  = 8'h80;
  localparam logic [15:0] NAR16 = 16'h8000;
  localparam logic [31:0] NAR32 = 32'h8000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [1:0]        pre;
    logic              nar_any;
  } result_t;

  // Flag indices that carry meaning in each mode (the lane's sign slot).
  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] pre);
    case (pre)
      PRE_P8:  lane_mask = 4'b1111;
      PRE_P16: lane_mask = 4'b1010;
      default: lane_mask = 4'b1000;
    endcase
  endfunction

endpackage

// File: rtl/posit_special_override.sv
// Applies per-lane zero/NaR overrides to a packed posit result word.
module posit_special_override
  import posit_pkg::*;
(
  input  logic [1:0]        pre,
  input  logic [WORD_W-1:0] res,
  input  logic [LANES-1:0]  zero,
  input  logic [LANES-1:0]  nar,
  output logic [WORD_W-1:0] data,
  output logic              nar_any,
  output logic [2:0]        nar_lanes
);

  logic [LANES-1:0] nar_act;
  logic [LANES-1:0] zero_act;

  assign nar_act  = nar & lane_mask(pre);
  assign zero_act = zero & lane_mask(pre);

  // NaR wins over zero on the same lane.
  always_comb begin
    data = res;
    case (pre)
      PRE_P8: begin
        for (int i = 0; i < 4; i++) begin
          if (nar_act[i])       data[8*i +: 8] = NAR8;
          else if (zero_act[i]) data[8*i +: 8] = 8'h00;
        end
      end
      PRE_P16: begin
        for (int i = 0; i < 2; i++) begin
          if (nar_act[2*i+1])       data[16*i +: 16] = NAR16;
          else if (zero_act[2*i+1]) data[16*i +: 16] = 16'h0000;
        end
      end
      default: begin
        if (nar_act[3])       data = NAR32;
        else if (zero_act[3]) data = '0;
      end
    endcase
  end

  assign nar_any   = |nar_act;
  assign nar_lanes = 3'(nar_act[0]) + 3'(nar_act[1]) + 3'(nar_act[2]) + 3'(nar_act[3]);

endmodule

// File: rtl/posit_result_buffer.sv
// Posit FMA output stage: special-case override at push, small valid/ready FIFO,
// registered head outputs and a saturating NaR lane counter.
module posit_result_buffer
  import posit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_pre,
  input  logic [WORD_W-1:0]        in_res,
  input  logic [LANES-1:0]         in_zero,
  input  logic [LANES-1:0]         in_nar,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W-1:0]        out_data,
  output logic [1:0]               out_pre,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_nar_any,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         nar_cnt,
  input  logic                     nar_clr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  result_t          mem     [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [OCC_W-1:0] count_n;
  logic             push, pop, head_is_new;

  logic [WORD_W-1:0] ov_data;
  logic              ov_nar_any;
  logic [2:0]        ov_nar_lanes;
  result_t           new_entry;

  result_t           head_n;
  logic [TAG_W-1:0]  head_tag_n;
  logic [SUM_W-1:0]  nar_sum;
  logic [CNT_W-1:0]  nar_cnt_n;

  posit_special_override u_override (
    .pre       (in_pre),
    .res       (in_res),
    .zero      (in_zero),
    .nar       (in_nar),
    .data      (ov_data),
    .nar_any   (ov_nar_any),
    .nar_lanes (ov_nar_lanes)
  );

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign new_entry = '{data: ov_data, pre: in_pre, nar_any: ov_nar_any};

  assign rd_ptr_n    = rd_ptr + PTR_W'(pop);
  assign count_n     = count + OCC_W'(push) - OCC_W'(pop);
  // The pushed entry lands at the head when nothing else remains after the pop.
  assign head_is_new = push & (count == OCC_W'(pop));

  // Next-cycle head view so the out_* ports can be registered.
  always_comb begin
    head_n     = '0;
    head_tag_n = '0;
    if (count_n != '0) begin
      if (head_is_new) begin
        head_n     = new_entry;
        head_tag_n = in_tag;
      end else begin
        head_n     = mem[rd_ptr_n];
        head_tag_n = tag_mem[rd_ptr_n];
      end
    end
  end

  // Saturating NaR lane accumulation; clear takes priority.
  always_comb begin
    nar_sum   = {1'b0, nar_cnt} + SUM_W'(ov_nar_lanes);
    nar_cnt_n = nar_cnt;
    if (nar_clr)      nar_cnt_n = '0;
    else if (push)    nar_cnt_n = nar_sum[CNT_W] ? {CNT_W{1'b1}} : nar_sum[CNT_W-1:0];
  end

  // Storage is only observable through count/pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]     <= new_entry;
      tag_mem[wr_ptr] <= in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_pre     <= '0;
      out_tag     <= '0;
      out_nar_any <= 1'b0;
      nar_cnt     <= '0;
    end else begin
      wr_ptr      <= wr_ptr + PTR_W'(push);
      rd_ptr      <= rd_ptr_n;
      count       <= count_n;
      in_ready    <= (count_n < OCC_W'(DEPTH));
      out_valid   <= (count_n != '0);
      out_data    <= head_n.data;
      out_pre     <= head_n.pre;
      out_tag     <= head_tag_n;
      out_nar_any <= head_n.nar_any;
      nar_cnt     <= nar_cnt_n;
    end
  end

endmodule
